bitbakery_minigame: RTL and testbench

BITBAKERY_MINIGAME -- requirements
Module: bitbakery_minigame

---
 rtl/bitbakery_minigame.sv | 236 +++++++++++++++++++++++
 tb/tb_bitbakery_minigame.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitbakery_minigame.sv
// bitbakery_minigame: "repeat the sequence" memory game.
//
// The game plays a fixed seven-element sequence (3,1,5,2,7,4,6). Round r
// shows the first r elements on leds, one at a time, each lit for
// SHOW_CYCLES cycles and followed by GAP_CYCLES dark cycles. The player then
// presses the matching buttons in order. A full round adds one to the score.
// The game is won after 4 rounds (dificuldade=0) or 7 rounds (dificuldade=1).
// A wrong press loses the game.
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   jogar        start/restart level (honoured in INICIAL and final states)
//   dificuldade  0 = 4 rounds, 1 = 7 rounds, latched while in PREPARA
//   botoes[6:0]  buttons, bit k = button k+1
//   estado[3:0]  current state code (doubles as the FSM debug view)
//   jogadas[6:0] last captured button vector
//   leds[2:0]    button number being shown (1..7), 0 = dark
//   pontuacao    completed rounds
//   pronto       game over (GANHOU / PERDEU / ESGOTOU)
//
// Interface note: there is no valid/ready handshake. A press is a one-cycle
// event: the cycle where any button is down and none was down on the
// previous cycle. It is consumed only in ESPERA. Otherwise it is dropped.
//
// Optional feature: define MINIGAME_TIMEOUT_EN to give each press
// TIMEOUT_CYCLES cycles. When the limit expires, the game enters ESGOTOU.
// A press that arrives on the last allowed cycle is still accepted.
module bitbakery_minigame #(
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       dificuldade,
  input  logic [6:0] botoes,
  output logic [3:0] estado,
  output logic [6:0] jogadas,
  output logic [2:0] leds,
  output logic [2:0] pontuacao,
  output logic       pronto
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    MOSTRA     = 4'd2,
    APAGA      = 4'd3,
    ESPERA     = 4'd4,
    COMPARA    = 4'd5,
    PROXIMA    = 4'd6,
    FIM_RODADA = 4'd7,
    GANHOU     = 4'd8,
    PERDEU     = 4'd9,
    ESGOTOU    = 4'd10
  } state_t;

  // One shared cycle counter serves the show, gap and (optional) timeout
  // phases. It is sized for the largest of the three.
  localparam int CNT_MAX_A = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef MINIGAME_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  function automatic logic [2:0] rom_at(input logic [2:0] k);
    case (k)
      3'd0:    rom_at = 3'd3;
      3'd1:    rom_at = 3'd1;
      3'd2:    rom_at = 3'd5;
      3'd3:    rom_at = 3'd2;
      3'd4:    rom_at = 3'd7;
      3'd5:    rom_at = 3'd4;
      default: rom_at = 3'd6;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;   // position inside the sequence
  logic [2:0]       rnd_q, rnd_d;   // current round, 1-based
  logic [2:0]       n_q, n_d;       // rounds needed to win
  logic [2:0]       pts_q, pts_d;
  logic [6:0]       jog_q, jog_d;
  logic             any_q;          // some button was down last cycle

  logic             press_edge;
  logic [6:0]       expect_vec;
  logic             more_in_round;

  assign press_edge    = (|botoes) & ~any_q;
  assign expect_vec    = 7'd1 << (rom_at(idx_q) - 3'd1);
  // idx_q < rnd_q <= 7 always, so idx_q + 1 cannot wrap.
  assign more_in_round = (idx_q + 3'd1) < rnd_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INICIAL;
      cnt_q   <= '0;
      idx_q   <= '0;
      rnd_q   <= '0;
      n_q     <= '0;
      pts_q   <= '0;
      jog_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rnd_q   <= rnd_d;
      n_q     <= n_d;
      pts_q   <= pts_d;
      jog_q   <= jog_d;
      any_q   <= |botoes;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rnd_d   = rnd_q;
    n_d     = n_q;
    pts_d   = pts_q;
    jog_d   = jog_q;

    case (state_q)
      INICIAL: begin
        if (jogar) begin
          state_d = PREPARA;
          pts_d   = '0;
          jog_d   = '0;
        end
      end
      PREPARA: begin
        n_d     = dificuldade ? 3'd7 : 3'd4;
        rnd_d   = 3'd1;
        idx_d   = 3'd0;
        cnt_d   = '0;
        pts_d   = '0;
        jog_d   = '0;
        state_d = MOSTRA;
      end
      MOSTRA: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = APAGA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      APAGA: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (more_in_round) begin
            idx_d   = idx_q + 3'd1;
            state_d = MOSTRA;
          end else begin
            idx_d   = 3'd0;
            state_d = ESPERA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ESPERA: begin
        if (press_edge) begin
          jog_d   = botoes;
          state_d = COMPARA;
        end
`ifdef MINIGAME_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          state_d = ESGOTOU;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      COMPARA: begin
        // An exact one-hot match is required. Any extra button is a miss.
        state_d = (jog_q == expect_vec) ? PROXIMA : PERDEU;
      end
      PROXIMA: begin
        if (more_in_round) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
          state_d = ESPERA;
        end else begin
          state_d = FIM_RODADA;
        end
      end
      FIM_RODADA: begin
        pts_d = rnd_q;
        if (rnd_q == n_q) begin
          state_d = GANHOU;
        end else begin
          rnd_d   = rnd_q + 3'd1;
          idx_d   = 3'd0;
          cnt_d   = '0;
          state_d = MOSTRA;
        end
      end
      GANHOU, PERDEU, ESGOTOU: begin
        if (jogar) begin
          state_d = PREPARA;
          pts_d   = '0;
          jog_d   = '0;
        end
      end
      default: begin
        state_d = INICIAL;
        cnt_d   = '0;
        idx_d   = '0;
        rnd_d   = '0;
        n_d     = '0;
        pts_d   = '0;
        jog_d   = '0;
      end
    endcase
  end

  // All outputs are decoded from registered state only.
  assign estado    = state_q;
  assign leds      = (state_q == MOSTRA) ? rom_at(idx_q) : 3'd0;
  assign pronto    = (state_q == GANHOU) || (state_q == PERDEU) || (state_q == ESGOTOU);
  assign jogadas   = (state_q == INICIAL) ? 7'd0 : jog_q;
  assign pontuacao = (state_q == INICIAL) ? 3'd0 : pts_q;

endmodule

// File: tb/tb_bitbakery_minigame.sv
// Testbench for bitbakery_minigame.
// The stimulus side plays whole games from the game rules: it shows rounds,
// presses the right or wrong buttons, holds buttons, and applies resets.
// For every clock edge it pushes the expected output vector
// {estado, leds, pontuacao, pronto, jogadas} into exp_q. A separate monitor
// pops one entry per cycle on the falling edge and compares it.
module tb_bitbakery_minigame;
  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int W    = 18;
`ifdef MINIGAME_TIMEOUT_EN
  localparam int LONG_WAIT = 63;
`else
  localparam int LONG_WAIT = 80;
`endif

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic       dificuldade = 1'b0;
  logic [6:0] botoes = 7'd0;
  logic [3:0] estado;
  logic [6:0] jogadas;
  logic [2:0] leds;
  logic [2:0] pontuacao;
  logic       pronto;

  always #5 clock = ~clock;

  bitbakery_minigame dut (
    .clock       (clock),
    .reset       (reset),
    .jogar       (jogar),
    .dificuldade (dificuldade),
    .botoes      (botoes),
    .estado      (estado),
    .jogadas     (jogadas),
    .leds        (leds),
    .pontuacao   (pontuacao),
    .pronto      (pronto)
  );

  // ---------------- reference model state ----------------
  int           rom_tab [7] = '{3, 1, 5, 2, 7, 4, 6};
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [2:0]   m_pts = 3'd0;
  logic [6:0]   m_jog = 7'd0;
  logic [3:0]   m_final = 4'd0;
  logic [6:0]   held = 7'd0;

  function automatic logic [6:0] want_btn(input int idx);
    int v;
    v = rom_tab[idx];
    return 7'(1 << (v - 1));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic j, input logic d, input logic [6:0] b,
                      input logic [3:0] e_est, input logic [2:0] e_leds,
                      input logic e_pronto, input string tag);
    jogar = j;
    dificuldade = d;
    botoes = b;
    @(posedge clock);
    exp_q.push_back({e_est, e_leds, m_pts, e_pronto, m_jog});
    tag_q.push_back(tag);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_pts = 3'd0;
    m_jog = 7'd0;
    tick(1'b1, rbit(), 7'($urandom_range(0, 127)), 4'd0, 3'd0, 1'b0, "reset");
    reset = 1'b0;
  endtask

  // Display of round r. The first tick leaves PREPARA or FIM_RODADA.
  // Stray presses here must be ignored. They stop two ticks before ESPERA.
  task automatic show_round(input int r, input logic dif, input logic first);
    int len;
    int pos;
    int el;
    logic [6:0] b;
    len = r * (SHOW + GAP) + 1;
    for (int k = 0; k < len; k++) begin
      b = 7'd0;
      if (k < len - 2 && $urandom_range(0, 3) == 0) b = 7'($urandom_range(1, 127));
      if (k == len - 1) begin
        tick(rbit(), rbit(), b, 4'd4, 3'd0, 1'b0, "enter_espera");
      end else begin
        pos = k % (SHOW + GAP);
        el  = k / (SHOW + GAP);
        if (pos < SHOW)
          tick(rbit(), (first && k == 0) ? dif : rbit(), b, 4'd2, 3'(rom_tab[el]), 1'b0, "mostra");
        else
          tick(rbit(), rbit(), b, 4'd3, 3'd0, 1'b0, "apaga");
      end
    end
    held = 7'd0;
  endtask

  task automatic start_game(input logic dif);
    m_pts = 3'd0;
    m_jog = 7'd0;
    tick(1'b1, ~dif, 7'd0, 4'd1, 3'd0, 1'b0, "start");
  endtask

  task automatic play_game(input logic dif, input int fail_r, input int fail_i,
                           input logic [6:0] wrong, input int long_wait,
                           input logic force_hold);
    int n;
    int w;
    logic [6:0] good;
    logic [6:0] press;
    logic [6:0] nb;
    n = dif ? 7 : 4;
    start_game(dif);
    for (int r = 1; r <= n; r++) begin
      show_round(r, dif, r == 1);
      for (int idx = 0; idx < r; idx++) begin
        if (held != 7'd0) begin
          repeat ($urandom_range(1, 2)) tick(rbit(), rbit(), held, 4'd4, 3'd0, 1'b0, "held_no_capture");
          tick(rbit(), rbit(), 7'd0, 4'd4, 3'd0, 1'b0, "release");
          held = 7'd0;
        end
        w = (r == 1 && idx == 0) ? long_wait : int'($urandom_range(0, 2));
        repeat (w) tick(rbit(), rbit(), 7'd0, 4'd4, 3'd0, 1'b0, "wait");
        good  = want_btn(idx);
        press = (r == fail_r && idx == fail_i) ? wrong : good;
        m_jog = press;
        tick(rbit(), rbit(), press, 4'd5, 3'd0, 1'b0, "capture");
        nb = (force_hold || rbit()) ? press : 7'd0;
        if (press != good) begin
          tick(rbit(), rbit(), nb, 4'd9, 3'd0, 1'b1, "perdeu");
          m_final = 4'd9;
          return;
        end
        tick(rbit(), rbit(), nb, 4'd6, 3'd0, 1'b0, "compara_ok");
        if (idx + 1 < r) begin
          tick(rbit(), rbit(), nb, 4'd4, 3'd0, 1'b0, "next_press");
          held = nb;
        end else begin
          tick(rbit(), rbit(), nb, 4'd7, 3'd0, 1'b0, "fim_rodada");
          m_pts = 3'(r);
          if (r == n) begin
            tick(rbit(), rbit(), 7'd0, 4'd8, 3'd0, 1'b1, "ganhou");
            m_final = 4'd8;
            return;
          end
        end
      end
    end
  endtask

  task automatic linger(input int k);
    repeat (k) tick(1'b0, rbit(), 7'($urandom_range(0, 127)), m_final, 3'd0, 1'b1, "final_hold");
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {estado, leds, pontuacao, pronto, jogadas};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s @%0t: got estado=%0d leds=%0d pontuacao=%0d pronto=%0d jogadas=%b, want estado=%0d leds=%0d pontuacao=%0d pronto=%0d jogadas=%b",
                 t, $time, a[17:14], a[13:11], a[10:8], a[7], a[6:0],
                 e[17:14], e[13:11], e[10:8], e[7], e[6:0]);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int dif_i;
    int fr;
    int fi;
    int n;
    logic [6:0] wr;

    do_reset();
    repeat (3) tick(1'b0, rbit(), 7'($urandom_range(0, 127)), 4'd0, 3'd0, 1'b0, "idle");

    // Easy game won with a long wait and forced button holds.
    play_game(1'b0, 0, 0, 7'd0, LONG_WAIT, 1'b1);
    linger(3);
    // Hard game: round 2, second press wrong.
    play_game(1'b1, 2, 1, 7'b0010000, 0, 1'b0);
    linger(2);
    // Two buttons at once on the first press.
    play_game(1'b0, 1, 0, 7'b0000101, 0, 1'b0);
    linger(2);

    for (int g = 0; g < 10; g++) begin
      dif_i = int'($urandom_range(0, 1));
      n = (dif_i != 0) ? 7 : 4;
      fr = 0;
      fi = 0;
      wr = 7'd0;
      if ($urandom_range(0, 2) != 0) begin
        fr = int'($urandom_range(1, n));
        fi = int'($urandom_range(0, fr - 1));
        do wr = 7'($urandom_range(1, 127)); while (wr == want_btn(fi));
      end
      play_game(1'(dif_i), fr, fi, wr, int'($urandom_range(0, 3)), 1'b0);
      linger(int'($urandom_range(1, 3)));
    end

`ifdef MINIGAME_TIMEOUT_EN
    start_game(1'b0);
    show_round(1, 1'b0, 1'b1);
    repeat (63) tick(rbit(), rbit(), 7'd0, 4'd4, 3'd0, 1'b0, "wait_timeout");
    tick(rbit(), rbit(), 7'd0, 4'd10, 3'd0, 1'b1, "esgotou");
    m_final = 4'd10;
    linger(3);
`endif

    // Reset in the middle of MOSTRA.
    start_game(1'b1);
    tick(rbit(), 1'b1, 7'd0, 4'd2, 3'(rom_tab[0]), 1'b0, "mostra_pre_reset");
    tick(rbit(), rbit(), 7'd0, 4'd2, 3'(rom_tab[0]), 1'b0, "mostra_pre_reset");
    do_reset();
    repeat (2) tick(1'b0, rbit(), 7'd0, 4'd0, 3'd0, 1'b0, "idle_after_reset");
    play_game(1'b0, 0, 0, 7'd0, 1, 1'b0);
    linger(2);

    jogar = 1'b0;
    botoes = 7'd0;
    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

endmodule
